// File: rtl/motion_bbox_ctrl.sv
// Motion bounding-box accumulator over a window of frames, with gray-image rectangle overlay.
// Optional: define MOTION_AREA_FILTER_EN to require MIN_PIXELS motion pixels for a valid box.
module motion_bbox_ctrl #(
   parameter int unsigned IMG_HDISP  = 640,
   parameter int unsigned IMG_VDISP  = 480,
   parameter int unsigned FRAME_WIN  = 10,
   parameter int unsigned MIN_PIXELS = 16,
   parameter logic [23:0] BOX_COLOR  = 24'hFF0000
) (
   input  logic        clk_vga,
   input  logic        sys_rst_n,
   input  logic        enable,
   input  logic        pix_valid,
   input  logic [11:0] lcd_xpos,
   input  logic [11:0] lcd_ypos,
   input  logic        pix_motion,
   input  logic [7:0]  pix_gray,
   output logic [23:0] lcd_data_in,
   output logic        box_valid,
   output logic [11:0] box_xmin,
   output logic [11:0] box_xmax,
   output logic [11:0] box_ymin,
   output logic [11:0] box_ymax,
   output logic [19:0] motion_cnt,
   output logic        win_done
);

   localparam logic [11:0] XLast   = 12'(IMG_HDISP - 1);
   localparam logic [11:0] YLast   = 12'(IMG_VDISP - 1);
   localparam logic [7:0]  WinLast = 8'(FRAME_WIN - 1);

   if (FRAME_WIN < 1 || FRAME_WIN > 255 || MIN_PIXELS > 32'hFFFFF) begin : g_param_check
      $error("motion_bbox_ctrl: FRAME_WIN or MIN_PIXELS out of range");
   end

   typedef enum logic [2:0] {StIdle, StAccum, StLatch, StClear, StWait} state_e;

   state_e      state_q, state_d;
   logic [11:0] acc_xmin_q, acc_xmax_q, acc_ymin_q, acc_ymax_q;
   logic [11:0] acc_xmin_d, acc_xmax_d, acc_ymin_d, acc_ymax_d;
   logic [19:0] acc_cnt_q, acc_cnt_d;
   logic [7:0]  win_cnt_q, win_cnt_d;
   logic [11:0] box_xmin_q, box_xmax_q, box_ymin_q, box_ymax_q;
   logic [11:0] box_xmin_d, box_xmax_d, box_ymin_d, box_ymax_d;
   logic [19:0] motion_cnt_q, motion_cnt_d;
   logic        box_valid_q, box_valid_d;
   logic        win_done_q, win_done_d;
   logic [23:0] lcd_q, lcd_d;

   logic fs, fe, hit, accum, reinit, publish, acc_ok;
   logic in_x, in_y, on_edge;

   assign fs  = pix_valid && (lcd_xpos == 12'd0) && (lcd_ypos == 12'd0);
   assign fe  = pix_valid && (lcd_xpos == XLast) && (lcd_ypos == YLast);
   assign hit = pix_valid && pix_motion;

`ifdef MOTION_AREA_FILTER_EN
   assign acc_ok = (acc_cnt_q >= 20'(MIN_PIXELS));
`else
   assign acc_ok = (acc_cnt_q != 20'd0);
`endif

   always_comb begin
      state_d      = state_q;
      acc_xmin_d   = acc_xmin_q;
      acc_xmax_d   = acc_xmax_q;
      acc_ymin_d   = acc_ymin_q;
      acc_ymax_d   = acc_ymax_q;
      acc_cnt_d    = acc_cnt_q;
      win_cnt_d    = win_cnt_q;
      box_xmin_d   = box_xmin_q;
      box_xmax_d   = box_xmax_q;
      box_ymin_d   = box_ymin_q;
      box_ymax_d   = box_ymax_q;
      motion_cnt_d = motion_cnt_q;
      box_valid_d  = box_valid_q;
      accum        = 1'b0;
      reinit       = 1'b0;
      publish      = 1'b0;

      // Idle keeps the accumulators at their init values, so accumulating the fs pixel is safe
      case (state_q)
         StIdle: begin
            if (fs) begin
               state_d = StAccum;
               accum   = 1'b1;
            end
         end
         StAccum: begin
            accum = 1'b1;
            if (fe) begin
               if (win_cnt_q == WinLast) state_d = StLatch;
               else                      win_cnt_d = win_cnt_q + 8'd1;
            end
         end
         StLatch: begin
            publish = 1'b1;
            state_d = StClear;
         end
         StClear: begin
            reinit  = 1'b1;
            state_d = StWait;
         end
         StWait: begin
            if (fs) begin
               state_d = StAccum;
               accum   = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (!enable) begin
         state_d = StIdle;
         accum   = 1'b0;
         publish = 1'b0;
         reinit  = 1'b1;
      end

      if (accum && hit) begin
         if (lcd_xpos < acc_xmin_q) acc_xmin_d = lcd_xpos;
         if (lcd_xpos > acc_xmax_q) acc_xmax_d = lcd_xpos;
         if (lcd_ypos < acc_ymin_q) acc_ymin_d = lcd_ypos;
         if (lcd_ypos > acc_ymax_q) acc_ymax_d = lcd_ypos;
         if (acc_cnt_q != 20'hFFFFF) acc_cnt_d = acc_cnt_q + 20'd1;
      end

      if (reinit) begin
         acc_xmin_d = XLast;
         acc_xmax_d = 12'd0;
         acc_ymin_d = YLast;
         acc_ymax_d = 12'd0;
         acc_cnt_d  = 20'd0;
         win_cnt_d  = 8'd0;
      end

      if (publish) begin
         box_xmin_d   = acc_xmin_q;
         box_xmax_d   = acc_xmax_q;
         box_ymin_d   = acc_ymin_q;
         box_ymax_d   = acc_ymax_q;
         motion_cnt_d = acc_cnt_q;
         box_valid_d  = acc_ok;
      end
      if (!enable) box_valid_d = 1'b0;

      win_done_d = publish;
   end

   // Overlay only reads the published box, which changes atomically at publish
   assign in_x    = (lcd_xpos >= box_xmin_q) && (lcd_xpos <= box_xmax_q);
   assign in_y    = (lcd_ypos >= box_ymin_q) && (lcd_ypos <= box_ymax_q);
   assign on_edge = (((lcd_xpos == box_xmin_q) || (lcd_xpos == box_xmax_q)) && in_y) ||
                    (((lcd_ypos == box_ymin_q) || (lcd_ypos == box_ymax_q)) && in_x);

   always_comb begin
      lcd_d = 24'd0;
      if (pix_valid) lcd_d = (box_valid_q && on_edge) ? BOX_COLOR : {3{pix_gray}};
   end

   always_ff @(posedge clk_vga or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= StIdle;
         acc_xmin_q   <= XLast;
         acc_xmax_q   <= 12'd0;
         acc_ymin_q   <= YLast;
         acc_ymax_q   <= 12'd0;
         acc_cnt_q    <= 20'd0;
         win_cnt_q    <= 8'd0;
         box_xmin_q   <= 12'd0;
         box_xmax_q   <= 12'd0;
         box_ymin_q   <= 12'd0;
         box_ymax_q   <= 12'd0;
         motion_cnt_q <= 20'd0;
         box_valid_q  <= 1'b0;
         win_done_q   <= 1'b0;
         lcd_q        <= 24'd0;
      end else begin
         state_q      <= state_d;
         acc_xmin_q   <= acc_xmin_d;
         acc_xmax_q   <= acc_xmax_d;
         acc_ymin_q   <= acc_ymin_d;
         acc_ymax_q   <= acc_ymax_d;
         acc_cnt_q    <= acc_cnt_d;
         win_cnt_q    <= win_cnt_d;
         box_xmin_q   <= box_xmin_d;
         box_xmax_q   <= box_xmax_d;
         box_ymin_q   <= box_ymin_d;
         box_ymax_q   <= box_ymax_d;
         motion_cnt_q <= motion_cnt_d;
         box_valid_q  <= box_valid_d;
         win_done_q   <= win_done_d;
         lcd_q        <= lcd_d;
      end
   end

   assign lcd_data_in = lcd_q;
   assign box_valid   = box_valid_q;
   assign box_xmin    = box_xmin_q;
   assign box_xmax    = box_xmax_q;
   assign box_ymin    = box_ymin_q;
   assign box_ymax    = box_ymax_q;
   assign motion_cnt  = motion_cnt_q;
   assign win_done    = win_done_q;

endmodule

// File: tb/tb_motion_bbox_ctrl.sv
// Self-checking bench for motion_bbox_ctrl: frame-level window model plus per-cycle output compare.
module tb_motion_bbox_ctrl;

   localparam int H    = 24;
   localparam int V    = 16;
   localparam int FW   = 2;
   localparam int MINP = 16;
   localparam logic [23:0] COLOR = 24'hFF0000;
   localparam logic [23:0] GRAY40 = 24'h404040;

   logic        clk_vga = 1'b0;
   logic        sys_rst_n = 1'b1;
   logic        enable = 1'b0;
   logic        pix_valid = 1'b0;
   logic [11:0] lcd_xpos = '0;
   logic [11:0] lcd_ypos = '0;
   logic        pix_motion = 1'b0;
   logic [7:0]  pix_gray = '0;
   logic [23:0] lcd_data_in;
   logic        box_valid;
   logic [11:0] box_xmin, box_xmax, box_ymin, box_ymax;
   logic [19:0] motion_cnt;
   logic        win_done;

   motion_bbox_ctrl #(
      .IMG_HDISP (H),
      .IMG_VDISP (V),
      .FRAME_WIN (FW),
      .MIN_PIXELS(MINP),
      .BOX_COLOR (COLOR)
   ) dut (
      .clk_vga    (clk_vga),
      .sys_rst_n  (sys_rst_n),
      .enable     (enable),
      .pix_valid  (pix_valid),
      .lcd_xpos   (lcd_xpos),
      .lcd_ypos   (lcd_ypos),
      .pix_motion (pix_motion),
      .pix_gray   (pix_gray),
      .lcd_data_in(lcd_data_in),
      .box_valid  (box_valid),
      .box_xmin   (box_xmin),
      .box_xmax   (box_xmax),
      .box_ymin   (box_ymin),
      .box_ymax   (box_ymax),
      .motion_cnt (motion_cnt),
      .win_done   (win_done)
   );

   always #5 clk_vga = ~clk_vga;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Motion pixels of the frame being driven
   int mq_x[$];
   int mq_y[$];

   function automatic bit is_mot(input int x, input int y);
      for (int i = 0; i < mq_x.size(); i++)
         if (mq_x[i] == x && mq_y[i] == y) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit win_ok(input int c);
`ifdef MOTION_AREA_FILTER_EN
      return c >= MINP;
`else
      return c != 0;
`endif
   endfunction

   // Frame-level window model (driver side) and publish request handed to the cycle model
   bit win_active = 0;
   int wframes = 0, wxmin = 0, wxmax = 0, wymin = 0, wymax = 0, wcnt = 0;
   bit pub_req = 0;
   bit req_valid = 0;
   int req_xmin = 0, req_xmax = 0, req_ymin = 0, req_ymax = 0, req_cnt = 0;

   // Published-box model and expected outputs
   bit          pv = 0;
   int          pxmin = 0, pxmax = 0, pymin = 0, pymax = 0, pcnt = 0;
   bit          pend = 0, pend_valid = 0;
   int          pend_xmin = 0, pend_xmax = 0, pend_ymin = 0, pend_ymax = 0, pend_cnt = 0;
   logic [23:0] exp_lcd = '0;
   bit          exp_done = 0;
   bit          last_valid = 0;
   int          last_x = 0, last_y = 0;
   logic [23:0] frame_out [0:H*V-1];

   function automatic bit on_box(input int x, input int y);
      return (((x == pxmin) || (x == pxmax)) && y >= pymin && y <= pymax) ||
             (((y == pymin) || (y == pymax)) && x >= pxmin && x <= pxmax);
   endfunction

   always @(posedge clk_vga or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         exp_lcd = '0; exp_done = 0; pv = 0; pend = 0; last_valid = 0;
         pxmin = 0; pxmax = 0; pymin = 0; pymax = 0; pcnt = 0;
      end else begin
         if (!pix_valid) exp_lcd = '0;
         else if (pv && on_box(int'(lcd_xpos), int'(lcd_ypos))) exp_lcd = COLOR;
         else exp_lcd = {3{pix_gray}};
         last_valid = pix_valid;
         last_x = int'(lcd_xpos);
         last_y = int'(lcd_ypos);
         exp_done = 0;
         if (pend && enable) begin
            pv = pend_valid; pxmin = pend_xmin; pxmax = pend_xmax;
            pymin = pend_ymin; pymax = pend_ymax; pcnt = pend_cnt;
            exp_done = 1;
         end
         pend = 0;
         if (pub_req && enable) begin
            pend = 1; pend_valid = req_valid; pend_cnt = req_cnt;
            pend_xmin = req_xmin; pend_xmax = req_xmax; pend_ymin = req_ymin; pend_ymax = req_ymax;
         end
         if (!enable) pv = 0;
      end
   end

   always @(negedge clk_vga) begin
      chk("lcd_data_in", 32'(lcd_data_in), 32'(exp_lcd));
      chk("win_done", 32'(win_done), 32'(exp_done));
      chk("box_valid", 32'(box_valid), 32'(pv));
      chk("box_xmin", 32'(box_xmin), 32'(pxmin));
      chk("box_xmax", 32'(box_xmax), 32'(pxmax));
      chk("box_ymin", 32'(box_ymin), 32'(pymin));
      chk("box_ymax", 32'(box_ymax), 32'(pymax));
      chk("motion_cnt", 32'(motion_cnt), 32'(pcnt));
      if (last_valid) frame_out[last_y*H + last_x] = lcd_data_in;
      if (win_done) done_cnt++;
   end

   task automatic vblank(input int n, input bit en);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_vga);
         pix_valid = 0; pub_req = 0; enable = en;
         if (!en) win_active = 0;
         pix_motion = (i % 2 == 0); lcd_xpos = '0; lcd_ypos = '0; pix_gray = 8'hAA;
      end
   endtask

   // g < 256: constant gray, else a position-dependent pattern; rst_at: pixel index of a reset pulse
   task automatic run_frame(input bit en, input int g, input int rst_at, input bit ben);
      bit m;
      for (int y = 0; y < V; y++) begin
         for (int x = 0; x < H; x++) begin
            @(negedge clk_vga);
            if (x == 0 && y == 0) begin
               enable = en;
               if (!en) win_active = 0;
            end
            m = is_mot(x, y);
            pix_valid = 1; lcd_xpos = 12'(x); lcd_ypos = 12'(y); pix_motion = m;
            pix_gray = (g < 256) ? 8'(g) : 8'(x*7 + y*13 + g);
            pub_req = 0;
            if (en) begin
               if (x == 0 && y == 0 && !win_active) begin
                  win_active = 1; wframes = 0; wcnt = 0;
                  wxmin = H-1; wxmax = 0; wymin = V-1; wymax = 0;
               end
               if (win_active && m) begin
                  if (x < wxmin) wxmin = x;
                  if (x > wxmax) wxmax = x;
                  if (y < wymin) wymin = y;
                  if (y > wymax) wymax = y;
                  wcnt++;
               end
               if (win_active && x == H-1 && y == V-1) begin
                  wframes++;
                  if (wframes == FW) begin
                     pub_req = 1; req_valid = win_ok(wcnt); req_cnt = wcnt;
                     req_xmin = wxmin; req_xmax = wxmax; req_ymin = wymin; req_ymax = wymax;
                     win_active = 0;
                  end
               end
            end
            if (y*H + x == rst_at) begin
               #2 sys_rst_n = 0;
               #2 sys_rst_n = 1;
               win_active = 0;
            end
         end
      end
      vblank(8, ben);
   endtask

   function automatic logic [23:0] px(input int x, input int y);
      return frame_out[y*H + x];
   endfunction

   initial begin
      #1 sys_rst_n = 0;
      repeat (3) @(negedge clk_vga);
      chk("rst lcd", 32'(lcd_data_in), 0);
      chk("rst box_valid", 32'(box_valid), 0);
      chk("rst box_xmax", 32'(box_xmax), 0);
      chk("rst motion_cnt", 32'(motion_cnt), 0);
      chk("rst win_done", 32'(win_done), 0);
      sys_rst_n = 1;

      mq_x = {4}; mq_y = {4};
      run_frame(0, 300, -1, 0);
      chk("idle done_cnt", 32'(done_cnt), 0);
      chk("idle box_valid", 32'(box_valid), 0);

      mq_x = {3};  mq_y = {2};  run_frame(1, 300, -1, 1);
      mq_x = {21}; mq_y = {13}; run_frame(1, 301, -1, 1);
      chk("w1 done_cnt", 32'(done_cnt), 1);
      chk("w1 box_xmin", 32'(box_xmin), 3);
      chk("w1 box_xmax", 32'(box_xmax), 21);
      chk("w1 box_ymin", 32'(box_ymin), 2);
      chk("w1 box_ymax", 32'(box_ymax), 13);
      chk("w1 motion_cnt", 32'(motion_cnt), 2);
      chk("w1 box_valid", 32'(box_valid), 1);

      mq_x = {}; mq_y = {};
      run_frame(1, 302, -1, 1);
      run_frame(1, 303, -1, 1);
      chk("w2 box_valid", 32'(box_valid), 0);
      chk("w2 motion_cnt", 32'(motion_cnt), 0);

      mq_x = {10}; mq_y = {5}; run_frame(1, 8'h40, -1, 1);
      chk("gray (10,6)", 32'(px(10, 6)), 32'(GRAY40));
      chk("gray (0,0)", 32'(px(0, 0)), 32'(GRAY40));
      mq_x = {20}; mq_y = {8}; run_frame(1, 304, -1, 1);
      chk("w3 box", {box_xmin[7:0], box_xmax[7:0], box_ymin[7:0], box_ymax[7:0]}, 32'h0A140508);

      mq_x = {1}; mq_y = {1}; run_frame(1, 8'h40, -1, 1);
      chk("edge (10,5)", 32'(px(10, 5)), 32'(COLOR));
      chk("edge (20,8)", 32'(px(20, 8)), 32'(COLOR));
      chk("edge (15,5)", 32'(px(15, 5)), 32'(COLOR));
      chk("edge (10,6)", 32'(px(10, 6)), 32'(COLOR));
      chk("inside (15,6)", 32'(px(15, 6)), 32'(GRAY40));
      chk("outside (9,5)", 32'(px(9, 5)), 32'(GRAY40));
      mq_x = {}; mq_y = {}; run_frame(1, 305, -1, 1);
      chk("w4 done_cnt", 32'(done_cnt), 4);

      mq_x = {2}; mq_y = {2}; run_frame(1, 8'h40, -1, 0);
      chk("dot (1,1)", 32'(px(1, 1)), 32'(COLOR));
      chk("dot (2,1)", 32'(px(2, 1)), 32'(GRAY40));
      chk("drop box_valid", 32'(box_valid), 0);
      chk("drop box_xmin hold", 32'(box_xmin), 1);
      chk("drop motion_cnt hold", 32'(motion_cnt), 1);
      mq_x = {0}; mq_y = {0}; run_frame(0, 306, -1, 0);
      mq_x = {5}; mq_y = {5}; run_frame(1, 307, -1, 1);
      mq_x = {7}; mq_y = {9}; run_frame(1, 308, -1, 1);
      chk("reentry done_cnt", 32'(done_cnt), 5);
      chk("reentry box", {box_xmin[7:0], box_xmax[7:0], box_ymin[7:0], box_ymax[7:0]}, 32'h05070509);

      mq_x = {}; mq_y = {};
      for (int i = 0; i < 15; i++) begin mq_x.push_back(i); mq_y.push_back(3); end
      run_frame(1, 309, -1, 1);
      mq_x = {}; mq_y = {}; run_frame(1, 310, -1, 1);
      chk("area15 motion_cnt", 32'(motion_cnt), 15);
`ifdef MOTION_AREA_FILTER_EN
      chk("area15 box_valid", 32'(box_valid), 0);
`else
      chk("area15 box_valid", 32'(box_valid), 1);
`endif
      for (int i = 0; i < 16; i++) begin mq_x.push_back(i); mq_y.push_back(4); end
      run_frame(1, 311, -1, 1);
      mq_x = {}; mq_y = {}; run_frame(1, 312, -1, 1);
      chk("area16 motion_cnt", 32'(motion_cnt), 16);
      chk("area16 box_valid", 32'(box_valid), 1);
      mq_x = {6}; mq_y = {6}; run_frame(1, 313, -1, 1);
      mq_x = {}; mq_y = {}; run_frame(1, 314, -1, 1);
      chk("area1 motion_cnt", 32'(motion_cnt), 1);
`ifdef MOTION_AREA_FILTER_EN
      chk("area1 box_valid", 32'(box_valid), 0);
`else
      chk("area1 box_valid", 32'(box_valid), 1);
`endif

      mq_x = {3}; mq_y = {3}; run_frame(1, 315, 100, 1);
      chk("midrst box_valid", 32'(box_valid), 0);
      chk("midrst box_xmax", 32'(box_xmax), 0);
      chk("midrst motion_cnt", 32'(motion_cnt), 0);
      chk("midrst done_cnt", 32'(done_cnt), 8);
      mq_x = {8}; mq_y = {8}; run_frame(1, 316, -1, 1);
      mq_x = {9}; mq_y = {3}; run_frame(1, 317, -1, 1);
      chk("recover done_cnt", 32'(done_cnt), 9);
      chk("recover box", {box_xmin[7:0], box_xmax[7:0], box_ymin[7:0], box_ymax[7:0]}, 32'h08090308);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/motion_bbox_ctrl.md
# motion_bbox_ctrl

Frame-window controller for the motion-detection display path, running in the clk_vga domain between the thresholded frame-difference stream (binary motion flag plus live gray pixel, qualified by the LCD data-request strobe) and the LCD driver's data input. It accumulates the motion bounding box across a programmable window of frames. At the end of each window it publishes one coherent box and restarts accumulation. It also generates the 24-bit LCD pixel, drawing a closed rectangle outline over the gray image.

## Interface
- IMG_HDISP, 640, active pixels per line
- IMG_VDISP, 480, active lines per frame
- FRAME_WIN, 10, frames per accumulation window (legal 1..255)
- MIN_PIXELS, 16, minimum motion-pixel count for a valid box (used only with the area filter)
- BOX_COLOR, 24'hFF0000, outline colour {R,G,B}

Ports:
- clk_vga  in  1  pixel clock
- sys_rst_n  in  1  reset; asynchronous, active-low
- enable  in  1  level; 0 forces IDLE
- pix_valid  in  1  active-pixel strobe from LCD timing
- lcd_xpos  in  12  current column, 0..IMG_HDISP-1 while pix_valid
- lcd_ypos  in  12  current row, 0..IMG_VDISP-1 while pix_valid
- pix_motion  in  1  thresholded difference flag for this pixel
- pix_gray  in  8  live gray pixel
- lcd_data_in  out  24  pixel to LCD driver
- box_valid  out  1  published box is meaningful
- box_xmin, box_xmax, box_ymin, box_ymax  out  12 each  published box
- motion_cnt  out  20  motion pixels in last window, saturating
- win_done  out  1  one-cycle pulse on publish

## Operation
- Frame start (fs): pix_valid && xpos==0 && ypos==0. Frame end (fe): pix_valid && xpos==IMG_HDISP-1 && ypos==IMG_VDISP-1.
- Accumulators: acc_xmin and acc_ymin init to IMG_HDISP-1 and IMG_VDISP-1; acc_xmax and acc_ymax init to 0; acc_cnt 20 bit init 0, saturating at 20'hFFFFF; win_cnt 8 bit.
- Update: in ACCUM, when pix_valid && pix_motion, do min/max compare-and-load per axis and acc_cnt+1.
- FSM:
  - IDLE: accumulators and win_cnt held at init. Go to ACCUM on enable && fs; that fs pixel is accumulated.
  - ACCUM: on fe, if win_cnt==FRAME_WIN-1 go to LATCH (the fe pixel is accumulated); otherwise win_cnt+1.
  - LATCH (1 cycle): load box_* from the accumulators and motion_cnt from acc_cnt. Set box_valid = (acc_cnt!=0). Pulse win_done. Go to CLEAR.
  - CLEAR (1 cycle): reinit accumulators, win_cnt=0. Go to WAIT.
  - WAIT: go to ACCUM on fs; that pixel is accumulated.
- Pixels arriving in LATCH, CLEAR or WAIT (excluding fs) are ignored. Under normal timing these states fall in vertical blanking.
- enable low in any state: next state IDLE, accumulators reinit, box_valid cleared, box_* and motion_cnt hold, no win_done.
- Overlay, registered:
  - pix_valid low: output 0.
  - box_valid && on_edge: output BOX_COLOR.
  - Otherwise output {pix_gray,pix_gray,pix_gray}.
  - on_edge = ((x==xmin || x==xmax) && ymin<=y<=ymax) || ((y==ymin || y==ymax) && xmin<=x<=xmax), using the published box. Corners are inclusive.
- A single-pixel box (xmin==xmax, ymin==ymax) draws one BOX_COLOR pixel.

## Timing
- Reset values: lcd_data_in=0, box_valid=0, box_xmin=box_xmax=box_ymin=box_ymax=0, motion_cnt=0, win_done=0, state IDLE.
- lcd_data_in latency: 1 clk_vga cycle from pix_valid/xpos/ypos/pix_gray.
- Publish: box_* and motion_cnt change in the cycle after the LATCH cycle, i.e. 2 cycles after the final fe. win_done is high for exactly that cycle.
- Published box changes only at publish or reset, so the overlay never shows a partially updated box.
- fe with FRAME_WIN==1: every frame publishes.
- Simultaneous fs and enable rising: accepted; the fs pixel is counted.
- Reset mid-window: immediate return to reset values; no win_done.

## Configuration
- MOTION_AREA_FILTER_EN defined: LATCH sets box_valid = (acc_cnt >= MIN_PIXELS). motion_cnt is still loaded.
- Undefined: box_valid = (acc_cnt != 0). MIN_PIXELS is unused.

## Test plan
- Reset, then idle stream: all outputs 0, box_valid=0, no win_done.
- FRAME_WIN=2, motion pixels at (100,50) frame 1 and (300,200) frame 2: one win_done after frame 2. Box = 100..300 x 50..200, motion_cnt=2, box_valid=1.
- Next window with no motion: box_valid=0, motion_cnt=0. The following frame outputs pure gray, e.g. pix_gray=8'h40 gives lcd_data_in=24'h404040.
- With a published box 10..20 x 5..8: pixels (10,5), (20,8), (15,5) and (10,6) give 24'hFF0000; (15,6) gives gray; (9,5) gives gray.
- enable dropped mid-window, then restored: no win_done, box_valid=0. The next publish reflects only frames after re-entry at fs.
- Area filter on, MIN_PIXELS=16: 15 motion pixels gives box_valid=0 and motion_cnt=15; 16 pixels gives box_valid=1. Area filter off: 1 pixel gives box_valid=1.
